non_max_suppression: RTL and testbench
======================================

# non_max_suppression

Canny stage 3: thins the Sobel gradient-magnitude frame by keeping only pixels that are local maxima along their quantised gradient direction. It consumes the magnitude and direction frames from the Sobel stage on that stage's completion pulse. It produces a thinned magnitude frame, a count of surviving edge pixels and a completion pulse for the double-threshold / hysteresis stage.

## Interface
Parameters:
- FRAME_WIDTH, 640, frame width in pixels
- FRAME_HEIGHT, 480, frame height in pixels
- PIX_WIDTH, 24, RGB pixel width; per-plane sample width is PIX_WIDTH/3 (8)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- sobel_val  input  1  Sobel frame complete; one-cycle pulse
- sobel_dir  input  [PIX_WIDTH/3-1:0] x [FRAME_HEIGHT][FRAME_WIDTH]  gradient direction; bits [1:0] used, upper bits ignored
- sobel_data  input  [PIX_WIDTH/3-1:0] x [FRAME_HEIGHT][FRAME_WIDTH]  gradient magnitude, unsigned
- nms_val  output  1  thinned frame complete; one-cycle pulse
- nms_busy  output  1  high while in PROCESS
- nms_ovf  output  1  sticky: sobel_val was seen while busy
- nms_cnt  output  $clog2(FRAME_WIDTH*FRAME_HEIGHT+1)  number of non-zero output pixels; final when nms_val is high
- nms_data  output  [PIX_WIDTH/3-1:0] x [FRAME_HEIGHT][FRAME_WIDTH]  suppressed magnitude frame

## Operation
- States:
  - IDLE: if sobel_val=1, go to PROCESS. On that same edge: clear nms_cnt and nms_ovf, and reset the counters to (0,0).
  - PROCESS: one pixel per cycle in raster order. proc_x runs 0..FRAME_WIDTH-1, then wraps and increments proc_y. At (FRAME_WIDTH-1, FRAME_HEIGHT-1), go to IDLE.
  - Unused encodings: go to IDLE.
- Neighbour pair selection by dir[1:0] at (y,x), with y increasing downward:
  - 00 (0°): (y,x-1) and (y,x+1)
  - 01 (45°): (y-1,x-1) and (y+1,x+1)
  - 10 (90°): (y-1,x) and (y+1,x)
  - 11 (135°): (y-1,x+1) and (y+1,x-1)
- Border rule: any neighbour outside the frame has magnitude 0. No reflection is applied.
- Output rule: nms_data[y][x] = m when m >= n1 and m >= n2, otherwise 0.
  - Ties are kept.
  - Comparison is 8-bit unsigned.
- nms_cnt increments by 1 for each pixel written with a non-zero value. It saturates at its maximum, which cannot be reached in normal use.
- Inputs must be stable throughout PROCESS; the block does not snapshot them. Upstream guarantees this because Sobel does not restart until a new Gaussian frame arrives.
- Overrun: sobel_val=1 while in PROCESS is ignored for control and sets nms_ovf=1. The current frame completes unchanged.

## Timing
- Reset values: nms_val=0, nms_busy=0, nms_ovf=0, nms_cnt=0, every nms_data element=0, state=IDLE, proc_x=proc_y=0.
- Edge 0: sobel_val is sampled high in IDLE. nms_busy rises after this edge.
- Edges 1..W*H: pixel k-1 of raster order is written on edge k.
- Edge W*H (the last-pixel write):
  - nms_val is set to 1, and nms_cnt is final.
  - State goes to IDLE and nms_busy falls.
- Edge W*H+1: nms_val clears. nms_val is exactly one cycle wide. Total latency is W*H+1 cycles from the sampled sobel_val to nms_val.
- Back-to-back frames: sobel_val high in the IDLE cycle where nms_val=1 starts a new frame on that edge. nms_val still clears on that edge.
- nms_data keeps the last frame until overwritten pixel by pixel. Consumers must read it only after nms_val.
- Reset mid-operation: the asynchronous return to IDLE applies all reset values immediately. No nms_val is produced for the aborted frame.

## Test plan
Bench parameters: FRAME_WIDTH=8, FRAME_HEIGHT=6 (W*H=48).
- Reset: assert rst_n low with random inputs -> every output is 0. After release with sobel_val=0 for 100 cycles, nms_busy=0 and nms_val never pulses.
- Uniform frame (all magnitudes 100, all dir 00), pulse sobel_val -> every nms_data element is 100, nms_cnt=48, nms_val is high exactly on cycle 49 after the start edge and lasts one cycle.
- Vertical ridge (column 3 = 200, all others 50, dir 00):
  - Columns 2 and 4 are 0.
  - Column 3 is 200.
  - Columns 0, 1, 5, 6 and 7 are 50.
  - nms_cnt=36.
- Diagonal peak (all magnitudes 0 except (2,2)=200 and (1,1)=(3,3)=150, all dir 01):
  - (2,2) is 200; (1,1) and (3,3) are suppressed to 0.
  - nms_cnt=1.
  - Repeat with dir 11 and peaks at (1,3),(2,2),(3,1): same result, with only (2,2) surviving.
- Overrun: a second sobel_val pulse at pixel 20 -> nms_ovf=1, nms_val still appears on cycle 49 with correct data. The next legitimate start clears nms_ovf to 0.
- Reset mid-frame: rst_n low at pixel 10 -> all nms_data elements are 0 and nms_busy=0, with no nms_val. A new start after release gives the correct 48-cycle frame.

Source files
------------

// File: rtl/non_max_suppression.sv
// Canny non-maximum suppression: walks the Sobel magnitude frame in raster order and keeps
// a pixel only if it is >= both neighbours along its quantised gradient direction.
module non_max_suppression #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIX_WIDTH    = 24
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sobel_val,
  input  logic [PIX_WIDTH/3-1:0]               sobel_dir  [FRAME_HEIGHT][FRAME_WIDTH],
  input  logic [PIX_WIDTH/3-1:0]               sobel_data [FRAME_HEIGHT][FRAME_WIDTH],
  output logic                                 nms_val,
  output logic                                 nms_busy,
  output logic                                 nms_ovf,
  output logic [$clog2(FRAME_WIDTH*FRAME_HEIGHT+1)-1:0] nms_cnt,
  output logic [PIX_WIDTH/3-1:0]               nms_data   [FRAME_HEIGHT][FRAME_WIDTH]
);

  localparam int DATA_W = PIX_WIDTH / 3;
  localparam int CNT_W  = $clog2(FRAME_WIDTH * FRAME_HEIGHT + 1);
  localparam int XW     = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW     = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PROCESS = 2'b01
  } state_t;

  state_t              state;
  logic [XW-1:0]       proc_x;
  logic [YW-1:0]       proc_y;

  int                  cx;
  int                  cy;
  logic [DATA_W-1:0]   dir_word;
  logic [1:0]          dir;
  logic [DATA_W-1:0]   mag;
  logic [DATA_W-1:0]   n1;
  logic [DATA_W-1:0]   n2;
  logic [DATA_W-1:0]   out_pix;
  logic                unused_dir_bits;

  // Out-of-frame neighbours read as zero magnitude.
  function automatic logic [DATA_W-1:0] mag_at(input int y, input int x);
    if (y < 0 || y >= FRAME_HEIGHT || x < 0 || x >= FRAME_WIDTH)
      return '0;
    return sobel_data[y[YW-1:0]][x[XW-1:0]];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}})
      return c;
    return c + 1'b1;
  endfunction

  always_comb begin
    cx       = int'(proc_x);
    cy       = int'(proc_y);
    dir_word = sobel_dir[proc_y][proc_x];
    dir      = dir_word[1:0];
    mag      = sobel_data[proc_y][proc_x];
    n1       = '0;
    n2       = '0;
    case (dir)
      2'b00: begin n1 = mag_at(cy,     cx - 1); n2 = mag_at(cy,     cx + 1); end
      2'b01: begin n1 = mag_at(cy - 1, cx - 1); n2 = mag_at(cy + 1, cx + 1); end
      2'b10: begin n1 = mag_at(cy - 1, cx);     n2 = mag_at(cy + 1, cx);     end
      default: begin n1 = mag_at(cy - 1, cx + 1); n2 = mag_at(cy + 1, cx - 1); end
    endcase
    out_pix = ((mag >= n1) && (mag >= n2)) ? mag : '0;
  end

  assign unused_dir_bits = ^dir_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      proc_x   <= '0;
      proc_y   <= '0;
      nms_val  <= 1'b0;
      nms_busy <= 1'b0;
      nms_ovf  <= 1'b0;
      nms_cnt  <= '0;
      for (int y = 0; y < FRAME_HEIGHT; y++)
        for (int x = 0; x < FRAME_WIDTH; x++)
          nms_data[y][x] <= '0;
    end else begin
      nms_val <= 1'b0;
      case (state)
        IDLE: begin
          if (sobel_val) begin
            state    <= PROCESS;
            nms_busy <= 1'b1;
            nms_cnt  <= '0;
            nms_ovf  <= 1'b0;
            proc_x   <= '0;
            proc_y   <= '0;
          end
        end
        PROCESS: begin
          if (sobel_val)
            nms_ovf <= 1'b1;
          nms_data[proc_y][proc_x] <= out_pix;
          if (out_pix != '0)
            nms_cnt <= sat_inc(nms_cnt);
          if (proc_x == X_LAST) begin
            proc_x <= '0;
            if (proc_y == Y_LAST) begin
              proc_y   <= '0;
              state    <= IDLE;
              nms_busy <= 1'b0;
              nms_val  <= 1'b1;
            end else begin
              proc_y <= proc_y + 1'b1;
            end
          end else begin
            proc_x <= proc_x + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          nms_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_non_max_suppression.sv
// Directed bench for non_max_suppression on an 8x6 frame with hand-built expected frames.
module tb_non_max_suppression;

  localparam int W = 8;
  localparam int H = 6;
  localparam int CW = $clog2(W * H + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sobel_val = 1'b0;
  logic [7:0]    sobel_dir  [H][W];
  logic [7:0]    sobel_data [H][W];
  logic          nms_val;
  logic          nms_busy;
  logic          nms_ovf;
  logic [CW-1:0] nms_cnt;
  logic [7:0]    nms_data   [H][W];
  logic [7:0]    exp_frame  [H][W];

  int checks = 0;
  int errors = 0;

  int   pulse_k, pulses, busy_n;
  logic ovf0;

  non_max_suppression #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIX_WIDTH(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sobel_val(sobel_val),
    .sobel_dir(sobel_dir), .sobel_data(sobel_data),
    .nms_val(nms_val), .nms_busy(nms_busy), .nms_ovf(nms_ovf),
    .nms_cnt(nms_cnt), .nms_data(nms_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_frame(input string tag);
    int nbad = 0;
    int by = 0, bx = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (nms_data[y][x] !== exp_frame[y][x]) begin
          if (nbad == 0) begin by = y; bx = x; end
          nbad++;
        end
    checks++;
    assert (nbad == 0) else begin
      errors++;
      $error("FAIL %s: %0d pixels differ, first (%0d,%0d) observed %0d expected %0d",
             tag, nbad, by, bx, nms_data[by][bx], exp_frame[by][bx]);
    end
  endtask

  task automatic fill(input logic [7:0] mag, input logic [7:0] d, input logic [7:0] e);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        sobel_data[y][x] = mag;
        sobel_dir[y][x]  = d;
        exp_frame[y][x]  = e;
      end
  endtask

  // Pulse sobel_val, then sample after edges 0..60. Optional overrun pulse / reset at a given edge.
  task automatic run_frame(input int ovf_at, input int rst_at,
                           output int pk, output int np, output int nb, output logic o0);
    pk = -1; np = 0; nb = 0; o0 = 1'bx;
    @(negedge clk);
    sobel_val = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      sobel_val = 1'b0;
      if (k == 0) o0 = nms_ovf;
      if (nms_val === 1'b1) begin np++; pk = k; end
      if (nms_busy === 1'b1) nb++;
      if (k == ovf_at) sobel_val = 1'b1;
      if (k == rst_at) rst_n = 1'b0;
    end
  endtask

  initial begin
    // Reset with random inputs and sobel_val toggling.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        sobel_data[y][x] = 8'($urandom);
        sobel_dir[y][x]  = 8'($urandom);
        exp_frame[y][x]  = 8'd0;
      end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sobel_val = ~sobel_val;
    end
    chk("rst_val", 32'(nms_val), 0);
    chk("rst_busy", 32'(nms_busy), 0);
    chk("rst_ovf", 32'(nms_ovf), 0);
    chk("rst_cnt", 32'(nms_cnt), 0);
    chk_frame("rst_frame");
    sobel_val = 1'b0;
    rst_n = 1'b1;
    pulses = 0; busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nms_val === 1'b1) pulses++;
      if (nms_busy === 1'b1) busy_n++;
    end
    chk("idle_val_pulses", 32'(pulses), 0);
    chk("idle_busy", 32'(busy_n), 0);

    // Uniform frame: everything ties, everything kept.
    fill(8'd100, 8'd0, 8'd100);
    run_frame(-1, -1, pulse_k, pulses, busy_n, ovf0);
    chk("uni_pulse_edge", 32'(pulse_k), 48);
    chk("uni_pulse_count", 32'(pulses), 1);
    chk("uni_busy_cycles", 32'(busy_n), 48);
    chk("uni_cnt", 32'(nms_cnt), 48);
    chk("uni_busy_end", 32'(nms_busy), 0);
    chk_frame("uni_frame");

    // Vertical ridge at column 3, horizontal comparison.
    fill(8'd50, 8'd0, 8'd50);
    for (int y = 0; y < H; y++) begin
      sobel_data[y][3] = 8'd200;
      exp_frame[y][2]  = 8'd0;
      exp_frame[y][3]  = 8'd200;
      exp_frame[y][4]  = 8'd0;
    end
    run_frame(-1, -1, pulse_k, pulses, busy_n, ovf0);
    chk("ridge_pulse_edge", 32'(pulse_k), 48);
    chk("ridge_cnt", 32'(nms_cnt), 36);
    chk_frame("ridge_frame");

    // Horizontal ridge at row 2, vertical comparison; dir upper bits set and ignored.
    fill(8'd50, 8'h06, 8'd50);
    for (int x = 0; x < W; x++) begin
      sobel_data[2][x] = 8'd200;
      exp_frame[1][x]  = 8'd0;
      exp_frame[2][x]  = 8'd200;
      exp_frame[3][x]  = 8'd0;
    end
    run_frame(-1, -1, pulse_k, pulses, busy_n, ovf0);
    chk("hridge_cnt", 32'(nms_cnt), 32);
    chk_frame("hridge_frame");

    // Diagonal 45 degrees.
    fill(8'd0, 8'd1, 8'd0);
    sobel_data[2][2] = 8'd200;
    sobel_data[1][1] = 8'd150;
    sobel_data[3][3] = 8'd150;
    exp_frame[2][2]  = 8'd200;
    run_frame(-1, -1, pulse_k, pulses, busy_n, ovf0);
    chk("diag45_cnt", 32'(nms_cnt), 1);
    chk_frame("diag45_frame");

    // Diagonal 135 degrees.
    fill(8'd0, 8'd3, 8'd0);
    sobel_data[2][2] = 8'd200;
    sobel_data[1][3] = 8'd150;
    sobel_data[3][1] = 8'd150;
    exp_frame[2][2]  = 8'd200;
    run_frame(-1, -1, pulse_k, pulses, busy_n, ovf0);
    chk("diag135_cnt", 32'(nms_cnt), 1);
    chk_frame("diag135_frame");

    // Overrun: second pulse mid-frame is flagged but does not disturb the frame.
    fill(8'd100, 8'd0, 8'd100);
    run_frame(20, -1, pulse_k, pulses, busy_n, ovf0);
    chk("ovr_flag", 32'(nms_ovf), 1);
    chk("ovr_pulse_edge", 32'(pulse_k), 48);
    chk("ovr_pulse_count", 32'(pulses), 1);
    chk("ovr_cnt", 32'(nms_cnt), 48);
    chk_frame("ovr_frame");
    run_frame(-1, -1, pulse_k, pulses, busy_n, ovf0);
    chk("ovr_clear_at_start", 32'(ovf0), 0);
    chk("ovr_clear_end", 32'(nms_ovf), 0);

    // Reset mid-frame after pixel 10.
    fill(8'd77, 8'd0, 8'd0);
    run_frame(-1, 10, pulse_k, pulses, busy_n, ovf0);
    chk("abort_pulses", 32'(pulses), 0);
    chk("abort_busy_cycles", 32'(busy_n), 11);
    chk("abort_busy", 32'(nms_busy), 0);
    chk("abort_cnt", 32'(nms_cnt), 0);
    chk_frame("abort_frame");
    rst_n = 1'b1;
    fill(8'd77, 8'd0, 8'd77);
    run_frame(-1, -1, pulse_k, pulses, busy_n, ovf0);
    chk("restart_pulse_edge", 32'(pulse_k), 48);
    chk("restart_cnt", 32'(nms_cnt), 48);
    chk_frame("restart_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
